// File: rtl/vtg_pkg.sv
// Shared widths, default raster constants, the totals record and the
// config clamp used by the video timing sequencer.
package vtg_pkg;

    localparam int VTG_HW = 10;
    localparam int VTG_VW = 10;

    localparam int DEF_H_ACTIVE     = 640;
    localparam int DEF_H_SYNC_START = 656;
    localparam int DEF_H_SYNC_END   = 752;
    localparam int DEF_H_TOTAL_RST  = 800;
    localparam int DEF_V_ACTIVE     = 480;
    localparam int DEF_V_SYNC_START = 490;
    localparam int DEF_V_SYNC_END   = 492;
    localparam int DEF_V_TOTAL_RST  = 525;

    typedef struct packed {
        logic [VTG_HW-1:0] h_total;
        logic [VTG_VW-1:0] v_total;
    } timing_t;

    typedef enum logic {
        CFG_IDLE = 1'b0,
        CFG_PEND = 1'b1
    } cfg_state_t;

    // A total shorter than the sync end would let the counter wrap before
    // the sync pulse finishes, so it is raised to one past the sync end.
    function automatic int unsigned clamp_total(input int unsigned req,
                                                input int unsigned floor_val);
        return (req < floor_val) ? floor_val : req;
    endfunction

endpackage

// File: rtl/wrap_counter.sv
// Enabled modulo counter: counts 0..limit and exposes the next-state value
// so that decoded strobes can be registered in step with the count.
module wrap_counter #(
    parameter int W = 10
) (
    input  logic         CK,
    input  logic         RN,
    input  logic         en,
    input  logic [W-1:0] limit,
    output logic [W-1:0] count,
    output logic [W-1:0] count_next,
    output logic         wrap
);

    assign wrap = en && (count == limit);

    always_comb begin
        count_next = count;
        if (wrap) begin
            count_next = '0;
        end else if (en) begin
            count_next = count + W'(1);
        end
    end

    always_ff @(posedge CK) begin
        if (!RN) begin
            count <= '0;
        end else begin
            count <= count_next;
        end
    end

endmodule

// File: rtl/video_timing_sequencer.sv
// Raster timing source: pixel/line counters, registered sync/blank/boundary
// strobes, and a config path that swaps line/frame totals at frame wrap.
module video_timing_sequencer
    import vtg_pkg::*;
#(
    parameter int HW           = VTG_HW,
    parameter int VW           = VTG_VW,
    parameter int H_ACTIVE     = DEF_H_ACTIVE,
    parameter int H_SYNC_START = DEF_H_SYNC_START,
    parameter int H_SYNC_END   = DEF_H_SYNC_END,
    parameter int H_TOTAL_RST  = DEF_H_TOTAL_RST,
    parameter int V_ACTIVE     = DEF_V_ACTIVE,
    parameter int V_SYNC_START = DEF_V_SYNC_START,
    parameter int V_SYNC_END   = DEF_V_SYNC_END,
    parameter int V_TOTAL_RST  = DEF_V_TOTAL_RST
) (
    input  logic          CK,
    input  logic          RN,
    input  logic          en,
    input  logic          cfg_valid,
    output logic          cfg_ready,
    input  logic [HW-1:0] cfg_h_total,
    input  logic [VW-1:0] cfg_v_total,
    output logic [HW-1:0] hcnt,
    output logic [VW-1:0] vcnt,
    output logic          hsync,
    output logic          vsync,
    output logic          csync,
    output logic          blank,
    output logic          line_start,
    output logic          frame_start,
    output logic          line_end
);

    localparam int unsigned H_MIN = H_SYNC_END + 1;
    localparam int unsigned V_MIN = V_SYNC_END + 1;
    localparam timing_t TIMING_RST = {HW'(H_TOTAL_RST), VW'(V_TOTAL_RST)};

    cfg_state_t    state;
    timing_t       shadow;
    timing_t       totals;
    timing_t       totals_next;
    timing_t       cfg_clamped;
    logic [HW-1:0] h_limit;
    logic [VW-1:0] v_limit;
    logic [HW-1:0] h_next;
    logic [VW-1:0] v_next;
    logic          h_wrap;
    logic          frame_wrap;
    logic          hs_n;
    logic          vs_n;
    logic          blank_n;
    logic          ls_n;
    logic          fs_n;
    logic          le_n;

    assign h_limit = totals.h_total - HW'(1);
    assign v_limit = totals.v_total - VW'(1);

    wrap_counter #(.W(HW)) u_hcnt (
        .CK         (CK),
        .RN         (RN),
        .en         (en),
        .limit      (h_limit),
        .count      (hcnt),
        .count_next (h_next),
        .wrap       (h_wrap)
    );

    // The line counter advances only on a pixel wrap, so its wrap is the frame wrap.
    wrap_counter #(.W(VW)) u_vcnt (
        .CK         (CK),
        .RN         (RN),
        .en         (h_wrap),
        .limit      (v_limit),
        .count      (vcnt),
        .count_next (v_next),
        .wrap       (frame_wrap)
    );

    always_comb begin
        cfg_clamped.h_total = HW'(clamp_total(32'(cfg_h_total), H_MIN));
        cfg_clamped.v_total = VW'(clamp_total(32'(cfg_v_total), V_MIN));
    end

    assign totals_next = (state == CFG_PEND && frame_wrap) ? shadow : totals;
    assign cfg_ready   = (state == CFG_IDLE);

    always_ff @(posedge CK) begin
        if (!RN) begin
            state  <= CFG_IDLE;
            shadow <= TIMING_RST;
            totals <= TIMING_RST;
        end else begin
            case (state)
                CFG_IDLE: begin
                    if (cfg_valid) begin
                        shadow <= cfg_clamped;
                        state  <= CFG_PEND;
                    end
                end
                CFG_PEND: begin
                    if (frame_wrap) begin
                        totals <= shadow;
                        state  <= CFG_IDLE;
                    end
                end
                default: state <= CFG_IDLE;
            endcase
        end
    end

    // Strobes decode the next-state counts so the registers line up with hcnt/vcnt.
    always_comb begin
        hs_n    = (h_next >= HW'(H_SYNC_START)) && (h_next < HW'(H_SYNC_END));
        vs_n    = (v_next >= VW'(V_SYNC_START)) && (v_next < VW'(V_SYNC_END));
        blank_n = (h_next >= HW'(H_ACTIVE)) || (v_next >= VW'(V_ACTIVE));
        ls_n    = (h_next == '0);
        fs_n    = (h_next == '0) && (v_next == '0);
        le_n    = (h_next == totals_next.h_total - HW'(1));
    end

    always_ff @(posedge CK) begin
        if (!RN) begin
            hsync       <= 1'b0;
            vsync       <= 1'b0;
            csync       <= 1'b0;
            blank       <= 1'b0;
            line_start  <= 1'b1;
            frame_start <= 1'b1;
            line_end    <= 1'b0;
        end else begin
            hsync       <= hs_n;
            vsync       <= vs_n;
            csync       <= hs_n ^ vs_n;
            blank       <= blank_n;
            line_start  <= ls_n;
            frame_start <= fs_n;
            line_end    <= le_n;
        end
    end

endmodule

// File: tb/tb_video_timing_sequencer.sv
// Bench: a default-timing instance and a shrunken-timing instance, both
// tracked per cycle by reference models through a scoreboard queue.
module tb_video_timing_sequencer;

    localparam int S_HA = 16, S_HSS = 18, S_HSE = 22, S_HT = 26;
    localparam int S_VA = 6,  S_VSS = 7,  S_VSE = 9,  S_VT = 11;

    typedef struct packed {
        logic [9:0] hcnt;
        logic [9:0] vcnt;
        logic       hsync;
        logic       vsync;
        logic       csync;
        logic       blank;
        logic       line_start;
        logic       frame_start;
        logic       line_end;
        logic       cfg_ready;
    } obs_t;

    typedef struct {
        int cfg_h;
        int cfg_v;
        int exp_h;
        int exp_v;
    } cfg_vec_t;

    logic       CK = 1'b0;
    logic       RN = 1'b0;
    logic       en = 1'b0;
    logic       cfg_valid = 1'b0;
    logic [9:0] cfg_h_total = '0;
    logic [9:0] cfg_v_total = '0;
    logic       full_cfg_valid = 1'b0;
    logic [9:0] full_cfg_h = '0;
    logic [9:0] full_cfg_v = '0;

    logic [9:0] f_hcnt, f_vcnt, s_hcnt, s_vcnt;
    logic f_hsync, f_vsync, f_csync, f_blank, f_line_start, f_frame_start, f_line_end, f_cfg_ready;
    logic s_hsync, s_vsync, s_csync, s_blank, s_line_start, s_frame_start, s_line_end, s_cfg_ready;

    int checks = 0;
    int errors = 0;
    int cycle = 0;

    int sm_h, sm_v, sm_ht, sm_vt, sm_sh, sm_sv;
    bit sm_pend;
    int fm_h, fm_v;

    obs_t sb_q[$];
    obs_t fb_q[$];
    cfg_vec_t vecs[5];

    always #5 CK = ~CK;

    video_timing_sequencer u_full (
        .CK(CK), .RN(RN), .en(en),
        .cfg_valid(full_cfg_valid), .cfg_ready(f_cfg_ready),
        .cfg_h_total(full_cfg_h), .cfg_v_total(full_cfg_v),
        .hcnt(f_hcnt), .vcnt(f_vcnt), .hsync(f_hsync), .vsync(f_vsync),
        .csync(f_csync), .blank(f_blank), .line_start(f_line_start),
        .frame_start(f_frame_start), .line_end(f_line_end)
    );

    video_timing_sequencer #(
        .H_ACTIVE(S_HA), .H_SYNC_START(S_HSS), .H_SYNC_END(S_HSE), .H_TOTAL_RST(S_HT),
        .V_ACTIVE(S_VA), .V_SYNC_START(S_VSS), .V_SYNC_END(S_VSE), .V_TOTAL_RST(S_VT)
    ) u_small (
        .CK(CK), .RN(RN), .en(en),
        .cfg_valid(cfg_valid), .cfg_ready(s_cfg_ready),
        .cfg_h_total(cfg_h_total), .cfg_v_total(cfg_v_total),
        .hcnt(s_hcnt), .vcnt(s_vcnt), .hsync(s_hsync), .vsync(s_vsync),
        .csync(s_csync), .blank(s_blank), .line_start(s_line_start),
        .frame_start(s_frame_start), .line_end(s_line_end)
    );

    function automatic obs_t expect_obs(int h, int v, int ht, int ha, int hss, int hse,
                                        int va, int vss, int vse, bit ready);
        obs_t o;
        o.hcnt        = 10'(h);
        o.vcnt        = 10'(v);
        o.hsync       = (h >= hss) && (h < hse);
        o.vsync       = (v >= vss) && (v < vse);
        o.csync       = o.hsync ^ o.vsync;
        o.blank       = (h >= ha) || (v >= va);
        o.line_start  = (h == 0);
        o.frame_start = (h == 0) && (v == 0);
        o.line_end    = (h == ht - 1);
        o.cfg_ready   = ready;
        return o;
    endfunction

    task automatic model_tick();
        bit fw, acc;
        int ch, cv;
        if (!RN) begin
            sm_h = 0; sm_v = 0; sm_ht = S_HT; sm_vt = S_VT; sm_pend = 0;
            fm_h = 0; fm_v = 0;
        end else begin
            fw  = en && (sm_h == sm_ht - 1) && (sm_v == sm_vt - 1);
            acc = cfg_valid && !sm_pend;
            if (en) begin
                if (sm_h == sm_ht - 1) begin
                    sm_h = 0;
                    sm_v = (sm_v == sm_vt - 1) ? 0 : sm_v + 1;
                end else sm_h++;
                if (fm_h == 799) begin
                    fm_h = 0;
                    fm_v = (fm_v == 524) ? 0 : fm_v + 1;
                end else fm_h++;
            end
            if (fw && sm_pend) begin
                sm_ht = sm_sh; sm_vt = sm_sv; sm_pend = 0;
            end else if (acc) begin
                ch = int'(cfg_h_total);
                cv = int'(cfg_v_total);
                sm_sh = (ch < S_HSE + 1) ? S_HSE + 1 : ch;
                sm_sv = (cv < S_VSE + 1) ? S_VSE + 1 : cv;
                sm_pend = 1;
            end
        end
    endtask

    task automatic check(string name, int got, int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s cycle=%0d got=%0d want=%0d", name, cycle, got, want);
        end
    endtask

    task automatic step();
        obs_t e, a;
        @(posedge CK);
        cycle++;
        model_tick();
        sb_q.push_back(expect_obs(sm_h, sm_v, sm_ht, S_HA, S_HSS, S_HSE, S_VA, S_VSS, S_VSE, !sm_pend));
        fb_q.push_back(expect_obs(fm_h, fm_v, 800, 640, 656, 752, 480, 490, 492, 1'b1));
        @(negedge CK);
        e = sb_q.pop_front();
        a = {s_hcnt, s_vcnt, s_hsync, s_vsync, s_csync, s_blank,
             s_line_start, s_frame_start, s_line_end, s_cfg_ready};
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL small_sb cycle=%0d got=%h want=%h", cycle, a, e);
        end
        e = fb_q.pop_front();
        a = {f_hcnt, f_vcnt, f_hsync, f_vsync, f_csync, f_blank,
             f_line_start, f_frame_start, f_line_end, f_cfg_ready};
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL full_sb cycle=%0d got=%h want=%h", cycle, a, e);
        end
    endtask

    // Counts cycles up to the next frame_start of the small instance.
    task automatic measure(output int line_len, output int frame_len);
        int n = 0;
        line_len = 0;
        do begin
            step();
            n++;
            if (line_len == 0 && s_line_start) line_len = n;
        end while (!s_frame_start && n < 5000);
        if (!s_frame_start) check("measure_timeout", 0, 1);
        frame_len = n;
    endtask

    initial begin
        int hs_count, ll, fl, n;
        vecs[0] = '{5,  3,  23, 10};
        vecs[1] = '{22, 9,  23, 10};
        vecs[2] = '{23, 10, 23, 10};
        vecs[3] = '{40, 12, 40, 12};
        vecs[4] = '{30, 25, 30, 25};

        RN = 0; en = 0;
        step(); step();
        check("rst_hcnt", int'(f_hcnt), 0);
        check("rst_vcnt", int'(f_vcnt), 0);
        check("rst_line_start", int'(f_line_start), 1);
        check("rst_frame_start", int'(f_frame_start), 1);
        check("rst_cfg_ready", int'(f_cfg_ready), 1);
        check("rst_hsync", int'(f_hsync), 0);
        check("rst_line_end", int'(f_line_end), 0);

        RN = 1; en = 1;
        hs_count = 0;
        for (int i = 1; i <= 800; i++) begin
            step();
            if (f_hsync) hs_count++;
            if (i == 799) begin
                check("line_end_799", int'(f_line_end), 1);
                check("hcnt_799", int'(f_hcnt), 799);
            end
        end
        check("hsync_cycles", hs_count, 96);
        check("wrap_hcnt", int'(f_hcnt), 0);
        check("wrap_vcnt", int'(f_vcnt), 1);
        check("wrap_line_start", int'(f_line_start), 1);

        RN = 0; step(); RN = 1;
        repeat (655) step();
        check("pre_hold_hcnt", int'(f_hcnt), 655);
        en = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            check("hold_hcnt", int'(f_hcnt), 655);
            check("hold_hsync", int'(f_hsync), 0);
        end
        en = 1;
        step();
        check("resume_hsync", int'(f_hsync), 1);
        check("resume_hcnt", int'(f_hcnt), 656);

        // Config offered on the exact frame-wrap cycle.
        RN = 0; step(); RN = 1;
        n = 0;
        while (!(sm_h == sm_ht - 1 && sm_v == sm_vt - 1) && n < 5000) begin
            step();
            n++;
        end
        check("wrap_wait", int'(sm_h == sm_ht - 1 && sm_v == sm_vt - 1), 1);
        cfg_h_total = 10'd24; cfg_v_total = 10'd12; cfg_valid = 1;
        step();
        cfg_valid = 0;
        check("wrapcfg_frame_start", int'(s_frame_start), 1);
        check("wrapcfg_ready", int'(s_cfg_ready), 0);
        measure(ll, fl);
        check("wrapcfg_old_line", ll, 26);
        check("wrapcfg_old_frame", fl, 286);
        check("wrapcfg_ready_after", int'(s_cfg_ready), 1);
        measure(ll, fl);
        check("wrapcfg_new_line", ll, 24);
        check("wrapcfg_new_frame", fl, 288);

        for (int k = 0; k < 5; k++) begin
            repeat (40) step();
            cfg_h_total = 10'(vecs[k].cfg_h);
            cfg_v_total = 10'(vecs[k].cfg_v);
            cfg_valid = 1;
            step();
            cfg_valid = 0;
            check("tbl_ready_low", int'(s_cfg_ready), 0);
            measure(ll, fl);
            check("tbl_ready_high", int'(s_cfg_ready), 1);
            measure(ll, fl);
            check("tbl_line_len", ll, vecs[k].exp_h);
            check("tbl_frame_len", fl, vecs[k].exp_h * vecs[k].exp_v);
        end

        // Reset in the middle of vsync with a config pending.
        RN = 0; step(); RN = 1;
        repeat (100) step();
        cfg_h_total = 10'd50; cfg_v_total = 10'd20; cfg_valid = 1;
        step();
        cfg_valid = 0;
        repeat (127) step();
        check("pend_hcnt", int'(s_hcnt), 20);
        check("pend_vcnt", int'(s_vcnt), 8);
        check("pend_vsync", int'(s_vsync), 1);
        check("pend_ready", int'(s_cfg_ready), 0);
        RN = 0; step(); RN = 1;
        check("prst_hcnt", int'(s_hcnt), 0);
        check("prst_vcnt", int'(s_vcnt), 0);
        check("prst_vsync", int'(s_vsync), 0);
        check("prst_ready", int'(s_cfg_ready), 1);
        measure(ll, fl);
        check("prst_line", ll, 26);
        check("prst_frame", fl, 286);
        measure(ll, fl);
        check("prst_frame2", fl, 286);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
